// File: rtl/ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller over a 1-cycle-latency dual-port RAM; capacity is RAM depth plus one head slot.
// Push-to-valid latency is 2 cycles; AFull refuses pushes while the RAM is full, and the head holds until ARdAck.
module ram_fifo_ctrl #(
  parameter int CAddrLen = 8,
  parameter int CDataLen = 16
) (
  input  logic                AClkH,
  input  logic                AResetN,
  input  logic                AClkHEn,
  input  logic                AClr,
  input  logic [CDataLen-1:0] AWrData,
  input  logic                AWrReq,
  output logic                AFull,
  output logic [CDataLen-1:0] ARdData,
  output logic                ARdValid,
  input  logic                ARdAck,
  output logic [CAddrLen:0]   ACount,
  output logic                AOvf,
  output logic                AUnf,
  output logic [CAddrLen-1:0] ARamWrAddr,
  output logic [CDataLen-1:0] ARamWrData,
  output logic                ARamWrEn,
  output logic [CAddrLen-1:0] ARamRdAddr,
  output logic                ARamRdEn,
  input  logic [CDataLen-1:0] ARamRdData
);

  localparam logic [CAddrLen:0]   CntFull = {1'b1, {CAddrLen{1'b0}}};
  localparam logic [CAddrLen:0]   CntOne  = (CAddrLen+1)'(1);
  localparam logic [CAddrLen-1:0] PtrOne  = (CAddrLen)'(1);

  logic                run_q, run_d;
  logic [CAddrLen-1:0] wr_ptr_q, wr_ptr_d;
  logic [CAddrLen-1:0] rd_ptr_q, rd_ptr_d;
  logic [CAddrLen:0]   ram_cnt_q, ram_cnt_d;
  logic                in_flight_q, in_flight_d;
  logic                out_vld_q, out_vld_d;
  logic [CDataLen-1:0] out_dat_q, out_dat_d;
  logic                ovf_q, ovf_d;
  logic                unf_q, unf_d;

  logic full;
  logic head;
  logic act;
  logic wr;
  logic pop;
  logic iss;

  assign act  = AClkHEn & ~AClr;
  assign full = ~run_q | (ram_cnt_q == CntFull);
  assign head = out_vld_q | in_flight_q;
  assign wr   = AWrReq & ~full & act;
  assign pop  = ARdAck & head & act;
  // Refill the head whenever it is empty or being consumed this cycle.
  assign iss  = (ram_cnt_q != '0) & (~head | pop) & run_q & act;

  assign AFull      = full;
  assign ARdValid   = head;
  assign ARdData    = in_flight_q ? ARamRdData : out_dat_q;
  assign ACount     = ram_cnt_q + {{CAddrLen{1'b0}}, head};
  assign AOvf       = ovf_q;
  assign AUnf       = unf_q;
  assign ARamWrAddr = wr_ptr_q;
  assign ARamWrData = AWrData;
  assign ARamWrEn   = wr;
  assign ARamRdAddr = rd_ptr_q;
  assign ARamRdEn   = iss;

  always_comb begin
    run_d       = run_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_cnt_d   = ram_cnt_q;
    in_flight_d = in_flight_q;
    out_vld_d   = out_vld_q;
    out_dat_d   = out_dat_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    if (AClkHEn) begin
      run_d = 1'b1;
      if (AClr) begin
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        ram_cnt_d   = '0;
        in_flight_d = 1'b0;
        out_vld_d   = 1'b0;
        out_dat_d   = '0;
        ovf_d       = 1'b0;
        unf_d       = 1'b0;
      end else begin
        if (wr) wr_ptr_d = wr_ptr_q + PtrOne;
        if (iss) rd_ptr_d = rd_ptr_q + PtrOne;
        if (wr && !iss) ram_cnt_d = ram_cnt_q + CntOne;
        else if (iss && !wr) ram_cnt_d = ram_cnt_q - CntOne;
        // The RAM output is only valid for one cycle, so an unconsumed word is parked in the head register.
        if (iss) begin
          in_flight_d = 1'b1;
          out_vld_d   = 1'b0;
        end else if (pop) begin
          in_flight_d = 1'b0;
          out_vld_d   = 1'b0;
        end else if (in_flight_q) begin
          out_dat_d   = ARamRdData;
          out_vld_d   = 1'b1;
          in_flight_d = 1'b0;
        end
        if (AWrReq && full && run_q) ovf_d = 1'b1;
        if (ARdAck && !head) unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge AClkH or negedge AResetN) begin
    if (!AResetN) begin
      run_q       <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_cnt_q   <= '0;
      in_flight_q <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      run_q       <= run_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_cnt_q   <= ram_cnt_d;
      in_flight_q <= in_flight_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl over a 4-deep RAM: directed steps then random traffic against a queue-based model.
module tb_ram_fifo_ctrl;

  localparam int AW = 2;
  localparam int DW = 16;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic          wr_req = 1'b0;
  logic          rd_ack = 1'b0;
  logic [DW-1:0] wr_dat = '0;

  logic          a_full;
  logic [DW-1:0] rd_dat;
  logic          rd_vld;
  logic [AW:0]   count;
  logic          ovf;
  logic          unf;
  logic [AW-1:0] ram_wa;
  logic [DW-1:0] ram_wd;
  logic          ram_we;
  logic [AW-1:0] ram_ra;
  logic          ram_re;
  logic [DW-1:0] ram_rd = '0;

  ram_fifo_ctrl #(.CAddrLen(AW), .CDataLen(DW)) dut (
    .AClkH      (clk),
    .AResetN    (rst_n),
    .AClkHEn    (en),
    .AClr       (clr),
    .AWrData    (wr_dat),
    .AWrReq     (wr_req),
    .AFull      (a_full),
    .ARdData    (rd_dat),
    .ARdValid   (rd_vld),
    .ARdAck     (rd_ack),
    .ACount     (count),
    .AOvf       (ovf),
    .AUnf       (unf),
    .ARamWrAddr (ram_wa),
    .ARamWrData (ram_wd),
    .ARamWrEn   (ram_we),
    .ARamRdAddr (ram_ra),
    .ARamRdEn   (ram_re),
    .ARamRdData (ram_rd)
  );

  always #5 clk = ~clk;

  // RAM with 1-cycle read, zero when not enabled, holding while the clock enable is low.
  logic [DW-1:0] mem [D];
  always @(posedge clk) begin
    if (en) begin
      if (ram_we) mem[ram_wa] <= ram_wd;
      ram_rd <= ram_re ? mem[ram_ra] : '0;
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            ts;
  } ent_t;

  ent_t q[$];
  int   ec = 0;
  bit   m_run = 0;
  bit   m_ovf = 0;
  bit   m_unf = 0;
  int   m_wp = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A word is visible at the head two enabled cycles after it was pushed, once it is at the front.
  function automatic bit m_vis();
    return (q.size() > 0) && (q[0].ts + 2 <= ec);
  endfunction

  function automatic bit m_full();
    return !m_run || ((q.size() - int'(m_vis())) == D);
  endfunction

  task automatic model_reset();
    q.delete();
    m_run = 0;
    m_ovf = 0;
    m_unf = 0;
    m_wp  = 0;
  endtask

  task automatic check_cycle();
    bit v;
    bit f;
    bit exp_we;
    v = m_vis();
    f = m_full();
    exp_we = en && !clr && wr_req && !f;
    chk("count", 32'(count), q.size());
    chk("valid", 32'(rd_vld), 32'(v));
    if (v) chk("data", 32'(rd_dat), 32'(q[0].d));
    chk("full", 32'(a_full), 32'(f));
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("unf", 32'(unf), 32'(m_unf));
    chk("ram_we", 32'(ram_we), 32'(exp_we));
    chk("ram_wdat", 32'(ram_wd), 32'(wr_dat));
    if (exp_we) chk("ram_waddr", 32'(ram_wa), m_wp);
    if (!en || clr || !m_run) chk("ram_re_idle", 32'(ram_re), 0);
  endtask

  task automatic model_edge();
    bit v;
    bit f;
    v = m_vis();
    f = m_full();
    if (en) begin
      if (clr) begin
        q.delete();
        m_ovf = 0;
        m_unf = 0;
        m_wp  = 0;
      end else begin
        if (wr_req && f && m_run) m_ovf = 1;
        if (rd_ack && !v) m_unf = 1;
        if (rd_ack && v) void'(q.pop_front());
        if (wr_req && !f) begin
          q.push_back('{wr_dat, ec});
          m_wp = (m_wp + 1) % D;
        end
      end
      m_run = 1;
      ec++;
    end
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic a, input logic e, input logic c);
    wr_req = w;
    wr_dat = d;
    rd_ack = a;
    en     = e;
    clr    = c;
    @(negedge clk);
    check_cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < D; i++) mem[i] = '0;

    // Reset values, with push requested to show strobes stay low.
    en = 1'b1;
    wr_req = 1'b1;
    wr_dat = 16'h0001;
    #2 rst_n = 1'b0;
    #3;
    chk("rst_full", 32'(a_full), 1);
    chk("rst_valid", 32'(rd_vld), 0);
    chk("rst_data", 32'(rd_dat), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_we", 32'(ram_we), 0);
    chk("rst_re", 32'(ram_re), 0);
    chk("rst_wa", 32'(ram_wa), 0);
    chk("rst_ra", 32'(ram_ra), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_unf", 32'(unf), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First push is refused for one cycle, then appears two cycles after acceptance.
    step(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'h0001, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("lat2_valid", 32'(rd_vld), 1);
    chk("lat2_data", 32'(rd_dat), 32'h0001);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Fill to capacity, then overflow.
    for (int i = 0; i < 5; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("fill_count", 32'(count), 5);
    chk("fill_full", 32'(a_full), 1);
    step(1'b1, 16'hA005, 1'b0, 1'b1, 1'b0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(count), 5);

    // Drain back-to-back.
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("drain_valid", 32'(rd_vld), 0);
    chk("drain_count", 32'(count), 0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

    // Streaming push and pop.
    for (int i = 0; i < 22; i++) begin
      step(i < 20, 16'(i), i >= 2, 1'b1, 1'b0);
      chk("stream_count_le2", 32'(count <= 2), 1);
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Underflow, then clear.
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    chk("unf_set", 32'(unf), 1);
    chk("unf_count", 32'(count), 0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    chk("unf_clr", 32'(unf), 0);
    step(1'b1, 16'h0055, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Clock enable low freezes everything; clear beats a concurrent push.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hB000 + 16'(i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hC000, 1'b1, 1'b0, 1'b0);
    chk("hold_count", 32'(count), 3);
    chk("hold_data", 32'(rd_dat), 32'hB000);
    step(1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b1);
    chk("clr_count", 32'(count), 0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with words queued.
    for (int i = 0; i < 3; i++) step(1'b1, 16'hD000 + 16'(i), 1'b0, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("arst_full", 32'(a_full), 1);
    chk("arst_valid", 32'(rd_vld), 0);
    chk("arst_count", 32'(count), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 16'hE000, 1'b0, 1'b1, 1'b0);

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 9) < 7, 16'($urandom), $urandom_range(0, 9) < 6,
           $urandom_range(0, 9) < 9, $urandom_range(0, 49) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ctrl.md
Name: ram_fifo_ctrl

Overview:
- First-word-fall-through FIFO controller for the team's dual-port RAM wrapper (RamDX), with both ports on one clock.
- It owns the write and read pointers, drives RAM port A for writes and port B for reads, and absorbs the RAM's 1-cycle read latency with a head slot.
- It sits between a streaming producer and a consumer, e.g. a UART/DMA buffer in front of the core bus.

Parameters:
CAddrLen, 8, RAM address width; RAM depth D = 2^CAddrLen; total capacity D+1 (RAM plus head slot).
CDataLen, 16, data word width.

Ports:
AClkH  in  1  clock
AResetN  in  1  asynchronous active-low reset
AClkHEn  in  1  clock enable; when 0, all state holds and RAM strobes are 0
AClr  in  1  synchronous clear (qualified by AClkHEn)
AWrData  in  CDataLen  push data
AWrReq  in  1  push request
AFull  out  1  push not accepted this cycle
ARdData  out  CDataLen  head word
ARdValid  out  1  head word valid
ARdAck  in  1  consume head
ACount  out  CAddrLen+1  words held (RAM plus head)
AOvf  out  1  sticky: push attempted while AFull
AUnf  out  1  sticky: ARdAck while ~ARdValid
ARamWrAddr  out  CAddrLen  RAM port A address
ARamWrData  out  CDataLen  RAM port A data, combinational copy of AWrData
ARamWrEn  out  1  RAM port A write
ARamRdAddr  out  CAddrLen  RAM port B address
ARamRdEn  out  1  RAM port B read enable; data appears on ARamRdData one enabled clock later, zero otherwise
ARamRdData  in  CDataLen  RAM port B data

Behaviour:
- Reset: FRun=0, FWrPtr=0, FRdPtr=0, FRamCnt=0, FInFlight=0, FOutVld=0, FOutData=0, AOvf=0, AUnf=0.
- Resulting output reset values: AFull=1, ARdValid=0, ARdData=0, ACount=0, all RAM strobes 0, both RAM addresses 0.
- FRun is set on the first enabled edge after reset. All strobes are gated by FRun, AClkHEn and ~AClr.
- AFull = ~FRun | (FRamCnt==D).
- Push: Wr = AWrReq & ~AFull & AClkHEn & ~AClr.
  - ARamWrEn=Wr, ARamWrAddr=FWrPtr.
  - On the edge, FWrPtr++ (wraps mod D) and FRamCnt++.
- Head: H = FOutVld | FInFlight (the two are mutually exclusive).
  - ARdValid = H.
  - ARdData = FInFlight ? ARamRdData : FOutData.
  - Pop = ARdAck & H & AClkHEn & ~AClr.
- Read issue: Iss = (FRamCnt!=0) & (~H | Pop), gated as above.
  - ARamRdEn=Iss, ARamRdAddr=FRdPtr.
  - On the edge, FRdPtr++, FRamCnt--, FInFlight<=1.
- When FInFlight & ~Pop & ~Iss: FOutData<=ARamRdData, FOutVld<=1, FInFlight<=0.
- When Pop & ~Iss: FOutVld<=0, FInFlight<=0.
- Simultaneous Wr and Iss: FRamCnt is unchanged. A RAM read/write collision is impossible because Iss needs FRamCnt!=0, so the pointers differ.
- AFull uses the current FRamCnt. At FRamCnt==D a push is refused even if Iss fires in the same cycle.
- Throughput is one word per cycle sustained. Latency: push at cycle t gives ARdValid at t+2.
- ACount = FRamCnt + H. Maximum value is D+1.
- AOvf is set by AWrReq & AFull & FRun & AClkHEn. AUnf is set by ARdAck & ~H & AClkHEn. Both are cleared only by AClr or reset.
- AClr has priority over push and pop in the same cycle. It zeroes all state except FRun, drops any in-flight word, and leaves RAM contents untouched.
- AClkHEn=0: all registers hold, RAM strobes are 0, and ARdData stays stable (the RAM output holds under its own clock enable).
- Asynchronous reset mid-operation: all stored words are discarded. Outputs reach reset values immediately; AFull=1 until the first enabled edge.

Decomposition:
- No shared package needed. D is a local constant derived from CAddrLen.
- No sub-module. The companion top level ram_fifo instantiates ram_fifo_ctrl plus RamDX (CAddrLen, CDataLen) with ARdEnA/ARdEnB tied high.

Test Plan (CAddrLen=2, CDataLen=16, RAM model with 1-cycle zeroed-when-idle read):
- Reset release, hold AWrReq=1 with data 16'h0001: AFull=1 for exactly one cycle, then the first push; ARdValid=1 two cycles after that push with ARdData=16'h0001.
- Fill with 16'hA000..16'hA004, no ARdAck: ACount reaches 5, AFull=1. A sixth push sets AOvf=1 and ACount stays 5.
- From full, ARdAck held high every cycle: reads 16'hA000..16'hA004 in order on consecutive cycles with no bubble, then ARdValid=0 and ACount=0.
- Continuous push and pop, 20 words 16'h0000..16'h0013: output matches input order and ACount never exceeds 2 once ARdAck is held high from the first ARdValid.
- ARdAck pulsed while empty: AUnf=1, ACount stays 0. AClr then clears AUnf, and the next push/pop works normally.
- With 3 words queued, AClkHEn=0 for 4 cycles while AWrReq=ARdAck=1: no state change and RAM strobes 0. Then assert AClr together with AWrReq: ACount=0 and no write occurs.
